// File: rtl/sort_cell_bank.sv
// sort_cell_bank: streaming insertion-sort cell that keeps the DEPTH strongest
// values in a sorted bank, forwards the evicted value downstream, and drains
// the bank weakest-first on an end-of-stream token. Uses the ap_ctrl_chain
// start/done/continue handshake with FIFO read/write interfaces.
module sort_cell_bank #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter bit                SIGNED   = 1'b1,
  parameter bit                DESCEND  = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic              start_full_n,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              start_out,
  output logic              start_write,
  input  logic [DATA_W:0]   in_V_dout,
  input  logic              in_V_empty_n,
  output logic              in_V_read,
  output logic [DATA_W:0]   out_V_din,
  input  logic              out_V_full_n,
  output logic              out_V_write
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [DATA_W-1:0] ins    [DEPTH];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_reg_q, done_reg_d;
  logic              start_once_q, start_once_d;

  logic [DATA_W-1:0] x;
  logic              x_last;
  logic [DATA_W-1:0] drain_word;
  logic              real_start;
  logic              fire;
  logic              done_now;

  assign x      = in_V_dout[DATA_W-1:0];
  assign x_last = in_V_dout[DATA_W];

  // Strict "a is stronger than b" under the configured order and signedness.
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic gt;
    if (SIGNED) gt = DESCEND ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    else        gt = DESCEND ? (a < b) : (a > b);
    return gt;
  endfunction

  // a is stronger than or equal to b.
  function automatic logic ge(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return !beats(b, a);
  endfunction

  // Bank after evicting slot[0] and inserting x above every equal-or-weaker slot.
  // Each slot takes its upper neighbour if x outranks that neighbour, otherwise x
  // if x outranks this slot, otherwise keeps its value; the bank being sorted
  // makes this equivalent to a shift-down-and-insert.
  always_comb begin
    ins = slot_q;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (ge(x, slot_q[i+1]))   ins[i] = slot_q[i+1];
      else if (ge(x, slot_q[i])) ins[i] = x;
      else                       ins[i] = slot_q[i];
    end
    ins[DEPTH-1] = ge(x, slot_q[DEPTH-1]) ? x : slot_q[DEPTH-1];
  end

  // Handshake, datapath steering and next-state selection.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    fire         = 1'b0;
    done_now     = 1'b0;
    in_V_read    = 1'b0;
    out_V_write  = 1'b0;
    out_V_din    = '0;
    drain_word   = slot_q[0];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == IDX_W'(i)) drain_word = slot_q[i];
    end

    real_start = (!start_full_n && !start_once_q) ? 1'b0 : ap_start;

    case (state_q)
      ST_RUN: begin
        fire = real_start & in_V_empty_n & out_V_full_n & ~done_reg_q;
        if (fire) begin
          in_V_read   = 1'b1;
          out_V_write = 1'b1;
          if (beats(x, slot_q[0])) begin
            out_V_din = {1'b0, slot_q[0]};
            slot_d    = ins;
          end else begin
            out_V_din = {1'b0, x};
          end
          if (x_last) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end else begin
            done_now = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_V_full_n) begin
          out_V_write = 1'b1;
          out_V_din   = {(idx_q == LAST_IDX), drain_word};
          if (idx_q == LAST_IDX) begin
            done_now = 1'b1;
            state_d  = ST_RUN;
            idx_d    = '0;
            for (int unsigned i = 0; i < DEPTH; i++) slot_d[i] = INIT_VAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    ap_ready    = done_now;
    ap_done     = done_reg_q | done_now;
    ap_idle     = (state_q == ST_RUN) & ~real_start;
    start_out   = real_start;
    start_write = real_start & ~start_once_q;

    if (ap_continue)  done_reg_d = 1'b0;
    else if (ap_done) done_reg_d = 1'b1;
    else              done_reg_d = done_reg_q;

    if (ap_ready)        start_once_d = 1'b0;
    else if (real_start) start_once_d = 1'b1;
    else                 start_once_d = start_once_q;
  end

  // State, bank and handshake registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      done_reg_q   <= 1'b0;
      start_once_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= INIT_VAL;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      done_reg_q   <= done_reg_d;
      start_once_q <= start_once_d;
      slot_q       <= slot_d;
    end
  end

endmodule

// File: tb/tb_sort_cell_bank.sv
// Bench for sort_cell_bank: two instances (DEPTH=4 unsigned, DEPTH=1 signed)
// share one input stream; each is checked every cycle against a sorted-bank
// reference model, plus a vector table and directed corner sequences.
module tb_sort_cell_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sfn, cont, en, fn;
  logic [32:0] din_in;
  logic [1:0]  done_o, idle_o, ready_o, sout_o, swr_o, rd_o, wr_o;
  logic [32:0] dout0, dout1;

  sort_cell_bank #(.DATA_W(32), .DEPTH(4), .SIGNED(1'b0), .DESCEND(1'b0), .INIT_VAL(32'd0)) u_d4 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .start_full_n(sfn),
    .ap_done(done_o[0]), .ap_continue(cont), .ap_idle(idle_o[0]), .ap_ready(ready_o[0]),
    .start_out(sout_o[0]), .start_write(swr_o[0]),
    .in_V_dout(din_in), .in_V_empty_n(en), .in_V_read(rd_o[0]),
    .out_V_din(dout0), .out_V_full_n(fn), .out_V_write(wr_o[0]));

  sort_cell_bank #(.DATA_W(32), .DEPTH(1), .SIGNED(1'b1), .DESCEND(1'b0), .INIT_VAL(32'd0)) u_d1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .start_full_n(sfn),
    .ap_done(done_o[1]), .ap_continue(cont), .ap_idle(idle_o[1]), .ap_ready(ready_o[1]),
    .start_out(sout_o[1]), .start_write(swr_o[1]),
    .in_V_dout(din_in), .in_V_empty_n(en), .in_V_read(rd_o[1]),
    .out_V_din(dout1), .out_V_full_n(fn), .out_V_write(wr_o[1]));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit cap    = 1'b0;
  logic [32:0] capq[$];

  // Reference model: bank kept sorted weakest-first by an order key.
  logic [31:0] mb [2][4];
  int          midx [2];
  bit          mdrain [2], mdone [2], monce [2];
  bit          e_rs [2], e_fire [2], e_dwr [2], e_ready [2], e_done [2];

  function automatic int dep(int m);
    return (m == 0) ? 4 : 1;
  endfunction

  // Signed order maps onto unsigned order by flipping the sign bit.
  function automatic logic [31:0] key(int m, logic [31:0] v);
    return (m == 1) ? (v ^ 32'h8000_0000) : v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) mb[m][i] = 32'd0;
      midx[m] = 0; mdrain[m] = 1'b0; mdone[m] = 1'b0; monce[m] = 1'b0;
    end
  endtask

  task automatic check(string nm, int m, logic [32:0] act, logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [depth%0d] cyc=%0d: got %0h expected %0h", nm, dep(m), cyc, act, exp);
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      logic [32:0] ed;
      logic [31:0] x;
      bit rs, fire, dwr, rdy, dn;
      x = din_in[31:0];
      ed = '0; fire = 1'b0; dwr = 1'b0; rdy = 1'b0;
      rs = (!sfn && !monce[m]) ? 1'b0 : start;
      if (!mdrain[m]) begin
        fire = rs && en && fn && !mdone[m];
        if (fire) begin
          ed  = {1'b0, (key(m, x) > key(m, mb[m][0])) ? mb[m][0] : x};
          rdy = !din_in[32];
        end
      end else if (fn) begin
        dwr = 1'b1;
        ed  = {midx[m] == dep(m) - 1, mb[m][midx[m]]};
        rdy = (midx[m] == dep(m) - 1);
      end
      dn = mdone[m] || rdy;
      e_rs[m] = rs; e_fire[m] = fire; e_dwr[m] = dwr; e_ready[m] = rdy; e_done[m] = dn;
      if (chk_en) begin
        check("in_V_read",   m, 33'(rd_o[m]),    33'(fire));
        check("out_V_write", m, 33'(wr_o[m]),    33'(fire || dwr));
        check("out_V_din",   m, (m == 0) ? dout0 : dout1, ed);
        check("ap_done",     m, 33'(done_o[m]),  33'(dn));
        check("ap_ready",    m, 33'(ready_o[m]), 33'(rdy));
        check("ap_idle",     m, 33'(idle_o[m]),  33'(!mdrain[m] && !rs));
        check("start_out",   m, 33'(sout_o[m]),  33'(rs));
        check("start_write", m, 33'(swr_o[m]),   33'(rs && !monce[m]));
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        monce[m] = e_ready[m] ? 1'b0 : (e_rs[m] ? 1'b1 : monce[m]);
        mdone[m] = cont ? 1'b0 : (e_done[m] ? 1'b1 : mdone[m]);
        if (e_fire[m]) begin
          if (key(m, din_in[31:0]) > key(m, mb[m][0])) begin
            mb[m][0] = din_in[31:0];
            for (int a = 0; a < dep(m); a++)
              for (int b = 0; b + 1 < dep(m); b++)
                if (key(m, mb[m][b]) > key(m, mb[m][b+1])) begin
                  logic [31:0] t;
                  t = mb[m][b]; mb[m][b] = mb[m][b+1]; mb[m][b+1] = t;
                end
          end
          if (din_in[32]) begin mdrain[m] = 1'b1; midx[m] = 0; end
        end else if (e_dwr[m]) begin
          if (midx[m] == dep(m) - 1) begin
            for (int i = 0; i < 4; i++) mb[m][i] = 32'd0;
            mdrain[m] = 1'b0; midx[m] = 0;
          end else begin
            midx[m]++;
          end
        end
      end
    end
  endtask

  task automatic drive(bit r, bit st, bit sf, bit ct, bit e, bit f, bit l, logic [31:0] d);
    rst = r; start = st; sfn = sf; cont = ct; en = e; fn = f; din_in = {l, d};
  endtask

  task automatic sample();
    @(negedge clk); #1;
    model_check();
    if (cap && wr_o[0]) capq.push_back(dout0);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic tok(logic [31:0] d, bit l);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, l, d);
    sample(); advance();
  endtask

  task automatic quiet(int n, bit f);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, f, 1'b0, 32'd0);
      sample(); advance();
    end
  endtask

  typedef struct {
    bit          r; bit e; bit l; logic [31:0] d;
    bit          w4; logic [32:0] o4; bit n4;
    bit          w1; logic [32:0] o1; bit n1;
  } vec_t;
  vec_t tbl [16];

  function automatic vec_t mk(bit r, bit e, bit l, logic [31:0] d,
                              bit w4, logic [32:0] o4, bit n4,
                              bit w1, logic [32:0] o1, bit n1);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.d = d;
    v.w4 = w4; v.o4 = o4; v.n4 = n4; v.w1 = w1; v.o1 = o1; v.n1 = n1;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,          1'b0, 33'h0,          1'b0, 1'b0, 33'h0,          1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'd4,          1'b1, 33'h0,          1'b1, 1'b1, 33'h0,          1'b1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'd2,          1'b1, 33'h0,          1'b1, 1'b1, 33'h2,          1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 32'd7,          1'b1, 33'h0,          1'b1, 1'b1, 33'h4,          1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 33'h0,          1'b1, 1'b1, 33'h0_FFFF_FFFF, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'd0,          1'b0, 33'h0,          1'b0, 1'b0, 33'h0,          1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'd5,          1'b1, 33'h0,          1'b1, 1'b1, 33'h0,          1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 32'd1,          1'b1, 33'h0,          1'b1, 1'b1, 33'h1,          1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'd9,          1'b1, 33'h0,          1'b1, 1'b1, 33'h5,          1'b1);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'd3,          1'b1, 33'h0,          1'b1, 1'b1, 33'h3,          1'b1);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 32'd7,          1'b1, 33'h1,          1'b0, 1'b1, 33'h7,          1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 33'h3,          1'b0, 1'b1, 33'h1_0000_0009, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 33'h5,          1'b0, 1'b0, 33'h0,          1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 33'h7,          1'b0, 1'b0, 33'h0,          1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 33'h1_0000_0009, 1'b1, 1'b0, 33'h0,          1'b0);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 32'd8,          1'b1, 33'h0,          1'b1, 1'b1, 33'h0,          1'b1);

    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;

    // Table vectors.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, 1'b1, 1'b1, 1'b1, tbl[i].e, 1'b1, tbl[i].l, tbl[i].d);
      sample();
      check("tbl_write4", 0, 33'(wr_o[0]),   33'(tbl[i].w4));
      check("tbl_dout4",  0, dout0,          tbl[i].o4);
      check("tbl_done4",  0, 33'(done_o[0]), 33'(tbl[i].n4));
      check("tbl_write1", 1, 33'(wr_o[1]),   33'(tbl[i].w1));
      check("tbl_dout1",  1, dout1,          tbl[i].o1);
      check("tbl_done1",  1, 33'(done_o[1]), 33'(tbl[i].n1));
      advance();
    end

    // Ties: equal values pass through or insert above equals, none lost.
    tok(32'd0, 1'b0); tok(32'd0, 1'b0); tok(32'd6, 1'b0); tok(32'd6, 1'b1);
    quiet(5, 1'b1);

    // Backpressure mid-drain: three stalled cycles, no skip or duplicate.
    tok(32'd10, 1'b0); tok(32'd20, 1'b0); tok(32'd30, 1'b0); tok(32'd40, 1'b0); tok(32'd25, 1'b1);
    cap = 1'b1;
    quiet(1, 1'b1); quiet(3, 1'b0); quiet(4, 1'b1);
    cap = 1'b0;
    check("bp_count", 0, 33'(capq.size()), 33'd4);
    if (capq.size() == 4) begin
      check("bp_word0", 0, capq[0], 33'h0_0000_0014);
      check("bp_word1", 0, capq[1], 33'h0_0000_0019);
      check("bp_word2", 0, capq[2], 33'h0_0000_001E);
      check("bp_word3", 0, capq[3], 33'h1_0000_0028);
    end

    // Reset on the second drain cycle discards the bank.
    tok(32'd5, 1'b0); tok(32'd6, 1'b0); tok(32'd7, 1'b0); tok(32'd8, 1'b1);
    quiet(1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    sample(); advance();
    quiet(1, 1'b1);
    check("rst_nowrite", 0, 33'(wr_o[0]), 33'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd8);
    sample();
    check("rst_init_emit", 0, dout0, 33'h0);
    advance();

    // Start FIFO full before any start: no start, no read, idle.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3);
    sample();
    check("sfull_read",  0, 33'(rd_o[0]),   33'd0);
    check("sfull_swr",   0, 33'(swr_o[0]),  33'd0);
    check("sfull_idle",  0, 33'(idle_o[0]), 33'd1);
    advance();

    // Done held without continue blocks further reads until continue.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd11);
    sample(); advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("hold_done", 0, 33'(done_o[0]), 33'd1);
      check("hold_read", 0, 33'(rd_o[0]),   33'd0);
      advance();
    end
    cont = 1'b1;
    sample(); advance();
    sample();
    check("resume_read", 0, 33'(rd_o[0]), 33'd1);
    advance();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(2, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom;
      drive(($urandom_range(199, 0) == 0), ($urandom_range(7, 0) != 0),
            ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
            ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
            ($urandom_range(5, 0) == 0), d);
      sample(); advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
